key_store: RTL and testbench

Key buffer for the stream cipher, directly downstream of `data_router`. It captures the key bytes the router delivers as single-cycle pulses and holds up to `KEY_MAX_BYTES` of them. It then presents one key byte at a time to the encryption block, stepping cyclically through the stored key each time the encryption block consumes a byte. A new key sequence automatically replaces the old key.

---
 rtl/stream_cipher_pkg.sv | 13 +
 rtl/key_store.sv | 105 ++++++++++
 tb/tb_key_store.sv | 138 +++++++++++++
 3 files changed

// File: rtl/stream_cipher_pkg.sv
// Shared types and constants for the stream cipher datapath.
package stream_cipher_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        LOADING,
        READY
    } key_store_state_t;

    localparam int         KEY_MAX_BYTES_DEFAULT = 16;
    localparam logic [7:0] KEY_NULL_BYTE         = 8'h00;

endpackage

// File: rtl/key_store.sv
// Key buffer: captures router key bytes, then presents them cyclically to the cipher.
//
// state   | meaning
// EMPTY   | no key stored, key_out forced to the null byte
// LOADING | key bytes being captured, reading already allowed
// READY   | key sealed by the first key_next, cycling only
module key_store
    import stream_cipher_pkg::*;
#(
    parameter int  KEY_MAX_BYTES = KEY_MAX_BYTES_DEFAULT,
    localparam int PTR_W         = $clog2(KEY_MAX_BYTES)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [7:0]       key_byte,
    input  logic             key_byte_pulse,
    input  logic             key_next,
    output logic [7:0]       key_out,
    output logic             key_valid,
    output logic [PTR_W:0]   key_len,
    output logic             key_overflow
);

    localparam logic [PTR_W:0] LEN_MAX = (PTR_W+1)'(KEY_MAX_BYTES);
    localparam logic [PTR_W:0] LEN_ONE = (PTR_W+1)'(1);

    key_store_state_t state, state_nxt;

    logic [7:0]       mem [KEY_MAX_BYTES];
    logic [PTR_W:0]   len, len_nxt;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt, rd_ptr_adv;
    logic [PTR_W:0]   rd_ptr_inc;
    logic             overflow, overflow_nxt;
    logic             wr_en;
    logic [PTR_W-1:0] wr_addr;

    // Wider compare so a full buffer wraps back to 0 instead of overflowing the pointer.
    assign rd_ptr_inc = {1'b0, rd_ptr} + LEN_ONE;
    assign rd_ptr_adv = (rd_ptr_inc == len) ? '0 : rd_ptr_inc[PTR_W-1:0];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= EMPTY;
            len      <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            len      <= len_nxt;
            rd_ptr   <= rd_ptr_nxt;
            overflow <= overflow_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        len_nxt      = len;
        rd_ptr_nxt   = rd_ptr;
        overflow_nxt = overflow;
        wr_en        = 1'b0;
        wr_addr      = '0;
        case (state)
            EMPTY, READY: begin
                if (key_byte_pulse) begin
                    wr_en        = 1'b1;
                    len_nxt      = LEN_ONE;
                    rd_ptr_nxt   = '0;
                    overflow_nxt = 1'b0;
                    state_nxt    = LOADING;
                end else if (key_next && state == READY) begin
                    rd_ptr_nxt = rd_ptr_adv;
                end
            end
            LOADING: begin
                if (key_byte_pulse) begin
                    if (len < LEN_MAX) begin
                        wr_en   = 1'b1;
                        wr_addr = len[PTR_W-1:0];
                        len_nxt = len + LEN_ONE;
                    end else begin
                        overflow_nxt = 1'b1;
                    end
                end else if (key_next) begin
                    rd_ptr_nxt = rd_ptr_adv;
                    state_nxt  = READY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < KEY_MAX_BYTES; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= key_byte;
        end
    end

    assign key_valid    = (state != EMPTY);
    assign key_out      = key_valid ? mem[rd_ptr] : KEY_NULL_BYTE;
    assign key_len      = len;
    assign key_overflow = overflow;

endmodule

// File: tb/tb_key_store.sv
// Self-checking bench for key_store: expected key bytes queued per stimulus, compared after the edge.
module tb_key_store;
    import stream_cipher_pkg::*;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] key_byte = '0;
    logic       key_byte_pulse = 1'b0;
    logic       key_next = 1'b0;
    logic [7:0] key_out;
    logic       key_valid;
    logic [4:0] key_len;
    logic       key_overflow;

    int n_checks = 0;
    int n_fails  = 0;
    logic [7:0] exp_q [$];

    key_store #(.KEY_MAX_BYTES(16)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .key_byte       (key_byte),
        .key_byte_pulse (key_byte_pulse),
        .key_next       (key_next),
        .key_out        (key_out),
        .key_valid      (key_valid),
        .key_len        (key_len),
        .key_overflow   (key_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; expected key_out is queued now and compared after the edge.
    task automatic step(input logic p, input logic [7:0] b, input logic n, input logic [7:0] exp_out);
        key_byte_pulse = p;
        key_byte       = b;
        key_next       = n;
        exp_q.push_back(exp_out);
        @(posedge clk);
        #1;
        key_byte_pulse = 1'b0;
        key_next       = 1'b0;
        check("key_out", key_out, exp_q.pop_front());
    endtask

    task automatic check_status(input string tag, input logic v, input logic [4:0] l, input logic o);
        check({tag, "_valid"}, key_valid, v);
        check({tag, "_len"}, key_len, l);
        check({tag, "_ovf"}, key_overflow, o);
    endtask

    logic [7:0] abc [3];
    logic [7:0] abc_exp [7];

    initial begin
        abc     = '{8'hA1, 8'hB2, 8'hC3};
        abc_exp = '{8'hB2, 8'hC3, 8'hA1, 8'hB2, 8'hC3, 8'hA1, 8'hB2};

        repeat (2) @(posedge clk);
        #1;
        check("rst_key_out", key_out, 8'h00);
        check_status("rst", 1'b0, 5'd0, 1'b0);
        nrst = 1'b1;

        // idle key_next in EMPTY is ignored
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1, 8'h00);
            check_status("empty_next", 1'b0, 5'd0, 1'b0);
        end

        // three-byte key, cycled
        for (int i = 0; i < 3; i++) step(1'b1, abc[i], 1'b0, 8'hA1);
        check_status("abc_load", 1'b1, 5'd3, 1'b0);
        check("abc_state_loading", 32'(dut.state), 32'(LOADING));
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 8'h00, 1'b1, abc_exp[i]);
            if (i == 0) check("abc_state_ready", 32'(dut.state), 32'(READY));
        end
        check_status("abc_cycle", 1'b1, 5'd3, 1'b0);

        // 17 bytes into a 16-deep buffer; last one dropped
        for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0, 8'h00);
        check_status("full", 1'b1, 5'd16, 1'b1);
        for (int i = 1; i <= 16; i++) step(1'b0, 8'h00, 1'b1, 8'(i % 16));
        check_status("full_wrap", 1'b1, 5'd16, 1'b1);

        // replace key in READY at rd_ptr = 2
        step(1'b0, 8'h00, 1'b1, 8'h01);
        step(1'b0, 8'h00, 1'b1, 8'h02);
        step(1'b1, 8'h5A, 1'b0, 8'h5A);
        check_status("rekey", 1'b1, 5'd1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 8'h5A);
        step(1'b0, 8'h00, 1'b1, 8'h5A);
        check("rekey_ptr", 32'(dut.rd_ptr), 32'd0);

        // simultaneous pulse and next while LOADING with len = 1: pulse wins
        step(1'b1, 8'h11, 1'b0, 8'h11);
        step(1'b1, 8'h77, 1'b1, 8'h11);
        check_status("simul", 1'b1, 5'd2, 1'b0);
        check("simul_state", 32'(dut.state), 32'(LOADING));
        check("simul_ptr", 32'(dut.rd_ptr), 32'd0);
        step(1'b0, 8'h00, 1'b1, 8'h77);
        step(1'b0, 8'h00, 1'b1, 8'h11);

        // asynchronous reset between edges
        #2;
        nrst = 1'b0;
        #1;
        check("arst_key_out", key_out, 8'h00);
        check_status("arst", 1'b0, 5'd0, 1'b0);
        @(posedge clk);
        #3;
        nrst = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 8'h42, 1'b0, 8'h42);
        check_status("fresh", 1'b1, 5'd1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 8'h42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
